// File: rtl/spdif_frame_assembler.sv
// spdif_frame_assembler: assembles decoded S/PDIF subframes into checked left/right sample pairs.
// Define SPDIF_CHANNEL_STATUS_EN to capture channel-status bits 0..31 into cs_word.
module spdif_frame_assembler #(
   parameter int OUT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 bit_strobe,
   input  logic                 bit_value,
   input  logic                 preamble_strobe,
   input  logic [1:0]           preamble_type,
   output logic [OUT_WIDTH-1:0] sample_left,
   output logic [OUT_WIDTH-1:0] sample_right,
   output logic                 sample_strobe,
   output logic                 block_start,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 locked,
   output logic [31:0]          cs_word,
   output logic                 cs_valid
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, DATA, FLAGS, CHECK} state_t;
   state_t state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic [23:0] sh_q, sh_d;
   logic par_q, par_d, c_q, c_d, pend_q, pend_d, b_q, b_d;
   logic [1:0] type_q, type_d, good_q, good_d, pre_type_q, pre_type_d;
   logic [OUT_WIDTH-1:0] left_q, left_d, sl_q, sl_d, sr_q, sr_d;
   logic ss_q, ss_d, bs_q, bs_d, pe_q, pe_d, fe_q, fe_d, pre_q, pre_d;
   logic [TW-1:0] to_q, to_d;
   logic strobe_any, tmo, take_pre, start, par_fin, good_left;
   logic [1:0] ptype;
   logic unused_bits;
   assign strobe_any = bit_strobe | preamble_strobe;
   assign tmo        = !strobe_any && (to_q == TW'(TIMEOUT_CYCLES - 1));
   assign take_pre   = preamble_strobe | pre_q;
   assign ptype      = preamble_strobe ? preamble_type : pre_type_q;
   assign par_fin    = par_q ^ bit_value;
   assign unused_bits = ^{sh_q[0], c_q, good_left};
   always_comb begin
      state_d = state_q; cnt_d = cnt_q; sh_d = sh_q; par_d = par_q; type_d = type_q;
      c_d = c_q; left_d = left_q; pend_d = pend_q; b_d = b_q; sl_d = sl_q; sr_d = sr_q;
      ss_d = 1'b0; bs_d = 1'b0; pe_d = 1'b0; fe_d = 1'b0; good_d = good_q;
      pre_d = 1'b0; pre_type_d = pre_type_q; start = 1'b0; good_left = 1'b0;
      to_d = strobe_any ? '0 : (to_q == TW'(TIMEOUT_CYCLES)) ? to_q : to_q + 1'b1;
      case (state_q)
         IDLE: begin
            fe_d  = take_pre && (ptype == 2'd3);
            start = take_pre && (ptype != 2'd3);
         end
         DATA, FLAGS: begin
            if (preamble_strobe) begin
               fe_d = 1'b1; pend_d = 1'b0; state_d = IDLE;
               start = (preamble_type != 2'd3);
            end else if (bit_strobe) begin
               par_d = par_fin;
               cnt_d = cnt_q + 5'd1;
               if (state_q == DATA) begin
                  sh_d = {bit_value, sh_q[23:1]};
                  state_d = (cnt_q == 5'd23) ? FLAGS : DATA;
               end else begin
                  c_d = (cnt_q == 5'd26) ? bit_value : c_q;
                  if (cnt_q == 5'd27) begin
                     // checks resolve on the P bit so pulses are visible during CHECK
                     state_d = CHECK; pend_d = 1'b0;
                     if (par_fin) pe_d = 1'b1;
                     else if (type_q != 2'd2) begin
                        good_left = 1'b1; fe_d = pend_q; pend_d = 1'b1;
                        left_d = sh_q[23 -: OUT_WIDTH]; b_d = (type_q == 2'd0);
                     end else if (pend_q) begin
                        ss_d = 1'b1; bs_d = b_q; sl_d = left_q; sr_d = sh_q[23 -: OUT_WIDTH];
                        good_d = good_q + {1'b0, good_q != 2'd3};
                     end else fe_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE; pre_d = preamble_strobe;
            pre_type_d = preamble_strobe ? preamble_type : pre_type_q;
         end
      endcase
      if (start) begin
         state_d = DATA; cnt_d = '0; sh_d = '0; par_d = 1'b0; type_d = ptype;
      end
      if (pe_d | fe_d) good_d = '0;
      if (tmo) begin
         state_d = IDLE; pend_d = 1'b0; good_d = '0;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE; cnt_q <= '0; sh_q <= '0; par_q <= 1'b0; type_q <= '0; c_q <= 1'b0;
         left_q <= '0; pend_q <= 1'b0; b_q <= 1'b0; sl_q <= '0; sr_q <= '0; ss_q <= 1'b0;
         bs_q <= 1'b0; pe_q <= 1'b0; fe_q <= 1'b0; good_q <= '0; to_q <= '0;
         pre_q <= 1'b0; pre_type_q <= '0;
      end else begin
         state_q <= state_d; cnt_q <= cnt_d; sh_q <= sh_d; par_q <= par_d; type_q <= type_d; c_q <= c_d;
         left_q <= left_d; pend_q <= pend_d; b_q <= b_d; sl_q <= sl_d; sr_q <= sr_d; ss_q <= ss_d;
         bs_q <= bs_d; pe_q <= pe_d; fe_q <= fe_d; good_q <= good_d; to_q <= to_d;
         pre_q <= pre_d; pre_type_q <= pre_type_d;
      end
   end
   assign sample_left   = sl_q;
   assign sample_right  = sr_q;
   assign sample_strobe = ss_q;
   assign block_start   = bs_q;
   assign parity_err    = pe_q;
   assign frame_err     = fe_q;
   assign locked        = good_q[1];
`ifdef SPDIF_CHANNEL_STATUS_EN
   logic [7:0] fc_q, fc_d, idx;
   logic [31:0] stage_q, stage_d, cs_q, cs_d;
   logic csok_q, csok_d, csv_q, csv_d, err;
   assign idx = (type_q == 2'd0) ? 8'd0 : fc_q;
   assign err = pe_d | fe_d;
   always_comb begin
      fc_d = fc_q; stage_d = stage_q; cs_d = cs_q; csv_d = 1'b0;
      csok_d = csok_q && !err;
      if (good_left) begin
         fc_d = (idx == 8'd191) ? 8'd0 : idx + 8'd1;
         csok_d = csok_d | (type_q == 2'd0);
         if (idx < 8'd32) stage_d[idx[4:0]] = c_q;
         if (idx == 8'd31 && csok_q && !err) begin
            cs_d = stage_d; csv_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fc_q <= '0; stage_q <= '0; cs_q <= '0; csok_q <= 1'b0; csv_q <= 1'b0;
      end else begin
         fc_q <= fc_d; stage_q <= stage_d; cs_q <= cs_d; csok_q <= csok_d; csv_q <= csv_d;
      end
   end
   assign cs_word  = cs_q;
   assign cs_valid = csv_q;
`else
   assign cs_word  = '0;
   assign cs_valid = 1'b0;
`endif
endmodule

// File: tb/tb_spdif_frame_assembler.sv
// tb_spdif_frame_assembler: directed + randomized subframes checked against a rule-level model.
module tb_spdif_frame_assembler;
   logic clk = 1'b0, reset_n = 1'b0;
   logic bit_strobe = 1'b0, bit_value = 1'b0, preamble_strobe = 1'b0;
   logic [1:0] preamble_type = '0;
   logic [15:0] sample_left, sample_right;
   logic sample_strobe, block_start, parity_err, frame_err, locked, cs_valid;
   logic [31:0] cs_word;
   int total = 0, bad = 0;
   bit m_pend = 0, m_b = 0, exp_csv = 0;
   logic [15:0] m_left = '0, m_sl = '0, m_sr = '0;
   int m_good = 0;
   localparam logic [31:0] CS_PAT = 32'h0200_0004;

   spdif_frame_assembler dut (
      .clk(clk), .reset_n(reset_n), .bit_strobe(bit_strobe), .bit_value(bit_value),
      .preamble_strobe(preamble_strobe), .preamble_type(preamble_type),
      .sample_left(sample_left), .sample_right(sample_right), .sample_strobe(sample_strobe),
      .block_start(block_start), .parity_err(parity_err), .frame_err(frame_err),
      .locked(locked), .cs_word(cs_word), .cs_valid(cs_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pre(input logic [1:0] t);
      preamble_strobe = 1'b1;
      preamble_type = t;
      tick();
      preamble_strobe = 1'b0;
   endtask

   task automatic bits(input logic [23:0] a, input bit c, input bit flip, input int n);
      logic [27:0] v;
      bit vv, uu;
      vv = 1'($urandom_range(0, 1));
      uu = 1'($urandom_range(0, 1));
      v = {^{c, uu, vv, a} ^ flip, c, uu, vv, a};
      for (int i = 0; i < n; i++) begin
         repeat ((i == 0) ? $urandom_range(1, 3) : $urandom_range(0, 2)) tick();
         bit_strobe = 1'b1;
         bit_value = v[i];
         tick();
         bit_strobe = 1'b0;
      end
   endtask

   task automatic expect_sub(input logic [1:0] t, input logic [23:0] a, input bit flip);
      bit ss, bs, pe, fe;
      ss = 0; bs = 0; pe = 0; fe = 0;
      if (flip) begin
         pe = 1; m_pend = 0; m_good = 0;
      end else if (t != 2'd2) begin
         if (m_pend) begin fe = 1; m_good = 0; end
         m_left = a[23:8]; m_pend = 1; m_b = (t == 2'd0);
      end else begin
         if (m_pend) begin
            ss = 1; bs = m_b; m_sl = m_left; m_sr = a[23:8];
            if (m_good < 3) m_good++;
         end else begin
            fe = 1; m_good = 0;
         end
         m_pend = 0;
      end
      chk("sample_strobe", 32'(sample_strobe), 32'(ss));
      chk("block_start", 32'(block_start), 32'(bs));
      chk("parity_err", 32'(parity_err), 32'(pe));
      chk("frame_err", 32'(frame_err), 32'(fe));
      chk("sample_left", 32'(sample_left), 32'(m_sl));
      chk("sample_right", 32'(sample_right), 32'(m_sr));
      chk("locked", 32'(locked), 32'(m_good >= 2));
      chk("cs_valid", 32'(cs_valid), 32'(exp_csv));
   endtask

   task automatic sub(input logic [1:0] t, input logic [23:0] a, input bit c, input bit flip);
      pre(t);
      bits(a, c, flip, 28);
      expect_sub(t, a, flip);
   endtask

   initial begin
      logic [1:0] t;
      logic [31:0] cs;
      cs = CS_PAT;
      repeat (3) tick();
      chk("rst_strobe", 32'(sample_strobe), 0);
      chk("rst_left", 32'(sample_left), 0);
      chk("rst_right", 32'(sample_right), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_perr", 32'(parity_err), 0);
      chk("rst_ferr", 32'(frame_err), 0);
      chk("rst_csv", 32'(cs_valid), 0);
      chk("rst_csw", cs_word, 0);
      reset_n = 1'b1;
      tick();
      sub(2'd0, 24'hAAFF12, 1'b0, 1'b0);
      sub(2'd2, 24'h123456, 1'b0, 1'b0);
      chk("first_left", 32'(sample_left), 32'hAAFF);
      chk("first_bs", 32'(block_start), 1);
      tick();
      chk("strobe_one_cycle", 32'(sample_strobe), 0);
      repeat (3) begin
         sub(2'd1, 24'h7FFF00, 1'b0, 1'b0);
         sub(2'd2, 24'h800000, 1'b0, 1'b0);
      end
      chk("lock_left", 32'(sample_left), 32'h7FFF);
      chk("lock_right", 32'(sample_right), 32'h8000);
      chk("lock_on", 32'(locked), 1);
      sub(2'd1, 24'h55AA00, 1'b1, 1'b0);
      sub(2'd2, 24'h0F0F0F, 1'b0, 1'b1);
      chk("perr_hold_left", 32'(sample_left), 32'h7FFF);
      chk("perr_unlock", 32'(locked), 0);
      pre(2'd0);
      bits(24'h111111, 1'b0, 1'b0, 10);
      preamble_strobe = 1'b1;
      preamble_type = 2'd1;
      bit_strobe = 1'b1;
      bit_value = 1'b1;
      tick();
      preamble_strobe = 1'b0;
      bit_strobe = 1'b0;
      chk("abort_ferr", 32'(frame_err), 1);
      chk("abort_nostrobe", 32'(sample_strobe), 0);
      m_pend = 0;
      m_good = 0;
      bits(24'hC0FFEE, 1'b0, 1'b0, 28);
      expect_sub(2'd1, 24'hC0FFEE, 1'b0);
      sub(2'd2, 24'hBEEF00, 1'b0, 1'b0);
      repeat (24) begin
         t = 2'($urandom_range(0, 2));
         sub(t, 24'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      end
      repeat (2) begin
         sub(2'd0, 24'($urandom), 1'b0, 1'b0);
         sub(2'd2, 24'($urandom), 1'b0, 1'b0);
      end
      chk("pre_tmo_locked", 32'(locked), 1);
      sub(2'd1, 24'h222222, 1'b0, 1'b0);
      repeat (1000) tick();
      chk("tmo_not_yet", 32'(locked), 1);
      repeat (30) tick();
      chk("tmo_unlock", 32'(locked), 0);
      chk("tmo_no_ferr", 32'(frame_err), 0);
      m_good = 0;
      m_pend = 0;
      sub(2'd2, 24'h333333, 1'b0, 1'b0);
      for (int f = 0; f < 32; f++) begin
`ifdef SPDIF_CHANNEL_STATUS_EN
         exp_csv = (f == 31);
`endif
         sub((f == 0) ? 2'd0 : 2'd1, 24'($urandom), cs[f], 1'b0);
         exp_csv = 0;
         sub(2'd2, 24'($urandom), 1'b0, 1'b0);
      end
`ifdef SPDIF_CHANNEL_STATUS_EN
      chk("cs_word", cs_word, CS_PAT);
`else
      chk("cs_word_off", cs_word, 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
